// File: rtl/fetch_controller_if.sv
// Handshake bundle for the fetch stage: instruction-memory request/response,
// next-PC redirect and the IF/ID output slot.
interface fetch_controller_if;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_ready;
  logic        fetch_misaligned;

  modport master (
    output imem_req_valid, imem_req_addr, if_valid, if_pc, if_instr, fetch_misaligned,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, if_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, if_valid, if_pc, if_instr, fetch_misaligned,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, if_ready
  );
endinterface

// File: rtl/fetch_controller.sv
// RV32 instruction-fetch sequencer: owns the PC, issues one memory request at a
// time and buffers returned words toward decode through an output slot plus skid.
module fetch_controller #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic                 clk,
  input logic                 rst_n,
  fetch_controller_if.master  bus
);

  typedef enum logic [1:0] {REQ, WAIT, HOLD} state_t;

  localparam logic [31:0] NOP = 32'h0000_0013;

  state_t      state, state_n;
  logic [31:0] pc;
  logic        slot_valid, skid_valid, drop, misaligned_q;
  logic [31:0] slot_pc, slot_instr, skid_pc, skid_instr;
  logic        req_valid, drain;

  // Requests are suppressed while in reset and whenever a redirect is arriving.
  assign req_valid = rst_n && (state == REQ) && !bus.redirect_valid;
  assign drain     = slot_valid && bus.if_ready;

  assign bus.imem_req_valid   = req_valid;
  assign bus.imem_req_addr    = pc;
  assign bus.if_valid         = slot_valid;
  assign bus.if_pc            = slot_pc;
  assign bus.if_instr         = slot_instr;
  assign bus.fetch_misaligned = misaligned_q;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= REQ;
    else        state <= state_n;
  end

  // A redirect while a response is still outstanding must stay in WAIT so the
  // stale word can be swallowed; a same-cycle response is simply discarded.
  always_comb begin
    state_n = state;
    if (bus.redirect_valid) begin
      state_n = (state == WAIT && !bus.imem_rsp_valid) ? WAIT : REQ;
    end else begin
      case (state)
        REQ:  if (req_valid && bus.imem_req_ready) state_n = WAIT;
        WAIT: if (bus.imem_rsp_valid) begin
                if (drop || !slot_valid || drain) state_n = REQ;
                else                              state_n = HOLD;
              end
        HOLD: if (drain) state_n = REQ;
        default: state_n = REQ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc           <= RESET_PC;
      slot_valid   <= 1'b0;
      slot_pc      <= 32'h0;
      slot_instr   <= NOP;
      skid_valid   <= 1'b0;
      skid_pc      <= 32'h0;
      skid_instr   <= NOP;
      drop         <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      misaligned_q <= bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00);
      if (bus.redirect_valid) begin
        pc         <= {bus.redirect_pc[31:2], 2'b00};
        slot_valid <= 1'b0;
        skid_valid <= 1'b0;
        drop       <= (state == WAIT) && !bus.imem_rsp_valid;
      end else begin
        if (drain) slot_valid <= 1'b0;
        case (state)
          WAIT: if (bus.imem_rsp_valid) begin
                  if (drop) begin
                    drop <= 1'b0;
                  end else if (!slot_valid || drain) begin
                    slot_valid <= 1'b1;
                    slot_pc    <= pc;
                    slot_instr <= bus.imem_rsp_data;
                    pc         <= pc + 32'd4;
                  end else begin
                    skid_valid <= 1'b1;
                    skid_pc    <= pc;
                    skid_instr <= bus.imem_rsp_data;
                    pc         <= pc + 32'd4;
                  end
                end
          HOLD: if (drain) begin
                  slot_valid <= skid_valid;
                  slot_pc    <= skid_pc;
                  slot_instr <= skid_instr;
                  skid_valid <= 1'b0;
                end
          default: ;
        endcase
      end
    end
  end

endmodule
